// File: rtl/pcie_rx_tlp_framer_if.sv
// pcie_rx_tlp_framer_if: PCIe core RX AXI-Stream as seen by the passive framer tap
interface pcie_rx_tlp_framer_if #(
  parameter int DATA_W = 64,
  parameter int TUSER_W = 22
);
  logic s_tready, s_tvalid, s_tlast;
  logic [DATA_W/8-1:0] s_tkeep;
  logic [DATA_W-1:0] s_tdata;
  logic [TUSER_W-1:0] s_tuser;
  modport master (output s_tready, s_tvalid, s_tlast, s_tkeep, s_tdata, s_tuser);
  modport slave (input s_tready, s_tvalid, s_tlast, s_tkeep, s_tdata, s_tuser);
endinterface

// File: rtl/pcie_rx_tlp_framer.sv
// pcie_rx_tlp_framer: snoops the RX stream, filters TLPs by type and writes accepted beats
// to the snoop FIFO with length/tag on the first entry and error terminators on aborts
module pcie_rx_tlp_framer #(
  parameter int DATA_W = 64,
  parameter int TUSER_W = 22,
  parameter int TIMEOUT_CYC = 500,
  parameter int TMO_W = 10,
  parameter int CNT_W = 16
) (
  input  logic pcie_clk,
  input  logic pcie_rst_n,
  pcie_rx_tlp_framer_if.slave rx,
  input  logic [5:0] cfg_type_en,
  input  logic full,
  output logic wr_en,
  output logic [12:0] din_tlp_len,
  output logic [7:0] din_tlp_tag,
  output logic din_tvalid,
  output logic din_tlast,
  output logic [DATA_W/8-1:0] din_tkeep,
  output logic [DATA_W-1:0] din_tdata,
  output logic [TUSER_W-1:0] din_tuser,
  output logic din_err,
  output logic [CNT_W-1:0] cnt_tlp,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_err
);
  localparam logic [1:0] IDLE = 2'd0, BODY = 2'd1, ERR_TERM = 2'd2, DRAIN = 2'd3;
  logic [1:0] state, nxt;
  logic s1_v, s1_last, s2_v, s2_last;
  logic [DATA_W/8-1:0] s1_keep, s2_keep;
  logic [DATA_W-1:0] s1_data, s2_data;
  logic [TUSER_W-1:0] s1_user, s2_user;
  logic [TMO_W-1:0] tmo;
  logic seen_last, eop, tmo_hit, hdr_wr, body_wr, term_wr, inc_drop, inc_tlp;
  logic [1:0] fmt;
  logic [4:0] typ;
  logic [5:0] hit;
  logic [10:0] len_dw;
  logic [12:0] tlp_len;
  logic [7:0] cpl_tag, tag;
  // A 64-bit completion header carries DW2 in the following beat, which sits in S1
  if (DATA_W == 64) begin : g_64
    assign cpl_tag = s1_data[15:8];
  end else begin : g_128
    assign cpl_tag = s2_data[79:72];
  end
  assign eop = s2_v & s2_last;
  assign tmo_hit = tmo == TMO_W'(TIMEOUT_CYC);
  assign fmt = s2_data[30:29];
  assign typ = s2_data[28:24];
  assign hit = {typ == 5'b01010 && fmt == 2'b10, typ == 5'b01010 && fmt == 2'b00,
                typ == 5'd0 && fmt == 2'b11, typ == 5'd0 && fmt == 2'b10,
                typ == 5'd0 && fmt == 2'b01, typ == 5'd0 && fmt == 2'b00};
  assign len_dw = {s2_data[9:0] == 10'd0, s2_data[9:0]};
  assign tlp_len = (fmt[1] ? {len_dw, 2'b00} : 13'd0) + (fmt[0] ? 13'd16 : 13'd12);
  assign tag = (hit[5] | hit[4]) ? cpl_tag : s2_data[47:40];
  always_comb begin
    nxt = state;
    hdr_wr = 1'b0;
    body_wr = 1'b0;
    term_wr = 1'b0;
    inc_drop = 1'b0;
    case (state)
      IDLE: if (s2_v && !(DATA_W == 64 && s2_last)) begin
        hdr_wr = |(hit & cfg_type_en) & !full;
        inc_drop = |(hit & cfg_type_en) & full;
        nxt = s2_last ? IDLE : hdr_wr ? BODY : DRAIN;
      end
      BODY: if (tmo_hit || (s2_v && full)) nxt = ERR_TERM;
        else if (s2_v) begin
          body_wr = 1'b1;
          nxt = s2_last ? IDLE : BODY;
        end
      ERR_TERM: if (!full) begin
        term_wr = 1'b1;
        nxt = (seen_last | eop) ? IDLE : DRAIN;
      end
      default: if (eop || tmo_hit) nxt = IDLE;
    endcase
  end
  assign inc_tlp = (hdr_wr | body_wr) & s2_last;
  assign wr_en = hdr_wr | body_wr | term_wr;
  assign din_tlp_len = hdr_wr ? tlp_len : 13'd0;
  assign din_tlp_tag = hdr_wr ? tag : 8'd0;
  assign din_tvalid = s2_v | term_wr;
  assign din_tlast = s2_last | term_wr;
  assign din_err = term_wr;
  assign din_tkeep = s2_keep;
  assign din_tdata = s2_data;
  assign din_tuser = s2_user;
  always_ff @(posedge pcie_clk or negedge pcie_rst_n)
    if (!pcie_rst_n) begin
      {s1_v, s1_last, s2_v, s2_last} <= '0;
      {s1_keep, s2_keep, s1_data, s2_data, s1_user, s2_user} <= '0;
      state <= IDLE;
      tmo <= '0;
      seen_last <= 1'b0;
      {cnt_tlp, cnt_drop, cnt_err} <= '0;
    end else begin
      s1_v <= rx.s_tvalid & rx.s_tready;
      s1_last <= rx.s_tlast;
      s1_keep <= rx.s_tkeep;
      s1_data <= rx.s_tdata;
      s1_user <= rx.s_tuser;
      {s2_v, s2_last, s2_keep, s2_data, s2_user} <= {s1_v, s1_last, s1_keep, s1_data, s1_user};
      state <= nxt;
      tmo <= (nxt != state && nxt != IDLE) ? '0 : (state == BODY || state == DRAIN) ? tmo + 1'b1 : tmo;
      // Remembers whether the aborted TLP's tlast already went by, so the terminator can skip DRAIN
      seen_last <= state == ERR_TERM ? seen_last | eop : eop;
      cnt_tlp <= cnt_tlp + CNT_W'(inc_tlp & ~&cnt_tlp);
      cnt_drop <= cnt_drop + CNT_W'(inc_drop & ~&cnt_drop);
      cnt_err <= cnt_err + CNT_W'(term_wr & ~&cnt_err);
    end
endmodule

// File: tb/tb_pcie_rx_tlp_framer.sv
// tb_pcie_rx_tlp_framer: directed tests of the RX TLP framer on 64-bit and 128-bit instances
module tb_pcie_rx_tlp_framer;
  logic pcie_clk = 1'b0, pcie_rst_n = 1'b0;
  always #5 pcie_clk = ~pcie_clk;
  pcie_rx_tlp_framer_if #(.DATA_W(64), .TUSER_W(22)) rx64 ();
  pcie_rx_tlp_framer_if #(.DATA_W(128), .TUSER_W(22)) rx128 ();
  logic [5:0] cfg;
  logic full;
  logic wr_en, din_tvalid, din_tlast, din_err;
  logic [12:0] din_tlp_len;
  logic [7:0] din_tlp_tag, din_tkeep;
  logic [63:0] din_tdata;
  logic [21:0] din_tuser;
  logic [15:0] cnt_tlp, cnt_drop, cnt_err;
  logic wr_en_b, din_tvalid_b, din_tlast_b, din_err_b;
  logic [12:0] din_tlp_len_b;
  logic [7:0] din_tlp_tag_b;
  logic [15:0] din_tkeep_b;
  logic [127:0] din_tdata_b;
  logic [21:0] din_tuser_b;
  logic [15:0] cnt_tlp_b, cnt_drop_b, cnt_err_b;
  int tests = 0, fails = 0;
  logic full_viol = 1'b0;
  typedef struct {
    logic [12:0] len;
    logic [7:0] tag;
    logic last, err, vld;
  } ent_t;
  ent_t q[$], qb[$];

  pcie_rx_tlp_framer #(.DATA_W(64)) dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .rx(rx64), .cfg_type_en(cfg), .full(full),
    .wr_en(wr_en), .din_tlp_len(din_tlp_len), .din_tlp_tag(din_tlp_tag), .din_tvalid(din_tvalid),
    .din_tlast(din_tlast), .din_tkeep(din_tkeep), .din_tdata(din_tdata), .din_tuser(din_tuser),
    .din_err(din_err), .cnt_tlp(cnt_tlp), .cnt_drop(cnt_drop), .cnt_err(cnt_err));

  pcie_rx_tlp_framer #(.DATA_W(128)) dut_b (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .rx(rx128), .cfg_type_en(cfg), .full(full),
    .wr_en(wr_en_b), .din_tlp_len(din_tlp_len_b), .din_tlp_tag(din_tlp_tag_b), .din_tvalid(din_tvalid_b),
    .din_tlast(din_tlast_b), .din_tkeep(din_tkeep_b), .din_tdata(din_tdata_b), .din_tuser(din_tuser_b),
    .din_err(din_err_b), .cnt_tlp(cnt_tlp_b), .cnt_drop(cnt_drop_b), .cnt_err(cnt_err_b));

  always @(negedge pcie_clk) begin
    if (wr_en) q.push_back('{din_tlp_len, din_tlp_tag, din_tlast, din_err, din_tvalid});
    if (wr_en_b) qb.push_back('{din_tlp_len_b, din_tlp_tag_b, din_tlast_b, din_err_b, din_tvalid_b});
    if ((wr_en || wr_en_b) && full) full_viol = 1'b1;
  end

  function automatic logic [31:0] dw0(input logic [1:0] f, input logic [4:0] t, input logic [9:0] l);
    return {1'b0, f, t, 14'd0, l};
  endfunction

  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic flush();
    repeat (4) tick();
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    rx64.s_tvalid = 1'b1;
    rx64.s_tdata = d;
    rx64.s_tlast = l;
    tick();
    rx64.s_tvalid = 1'b0;
    rx64.s_tlast = 1'b0;
  endtask

  task automatic send_b(input logic [127:0] d, input logic l);
    rx128.s_tvalid = 1'b1;
    rx128.s_tdata = d;
    rx128.s_tlast = l;
    tick();
    rx128.s_tvalid = 1'b0;
    rx128.s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests++; if ({wr_en, din_tvalid, din_tlast, din_err, din_tlp_len, din_tlp_tag, din_tdata} !== '0) begin
      fails++; $display("FAIL reset_outputs got wr=%b len=%0d tag=%h data=%h exp all 0", wr_en, din_tlp_len, din_tlp_tag, din_tdata); end
    pcie_rst_n = 1'b1;
    tick();
    tests++; if ({cnt_tlp, cnt_drop, cnt_err} !== 48'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", cnt_tlp, cnt_drop, cnt_err); end
    tests++; if ({wr_en, wr_en_b, cnt_tlp_b} !== 18'd0) begin
      fails++; $display("FAIL reset_idle got wr=%b wr_b=%b cnt_b=%0d exp 0", wr_en, wr_en_b, cnt_tlp_b); end
  endtask

  task automatic test_mwr3();
    q.delete();
    send({32'h0000_A500, dw0(2'b10, 5'd0, 10'd4)}, 1'b0);
    send(64'h1111_1111_2222_2222, 1'b0);
    rx64.s_tvalid = 1'b1;
    rx64.s_tready = 1'b0;
    rx64.s_tdata = 64'hDEAD_BEEF;
    tick();
    rx64.s_tready = 1'b1;
    send(64'h3333_3333_4444_4444, 1'b1);
    flush();
    tests++; if (q.size() !== 3) begin fails++; $display("FAIL mwr3_writes got %0d exp 3", q.size()); end
    tests++; if ({q[0].len, q[0].tag, q[0].last, q[0].err} !== {13'd28, 8'hA5, 2'b00}) begin
      fails++; $display("FAIL mwr3_hdr got len=%0d tag=%h exp len=28 tag=a5", q[0].len, q[0].tag); end
    tests++; if ({q[1].len, q[1].tag, q[1].last, q[1].vld} !== {13'd0, 8'd0, 2'b01}) begin
      fails++; $display("FAIL mwr3_mid got len=%0d tag=%h last=%b vld=%b exp 0/00/0/1", q[1].len, q[1].tag, q[1].last, q[1].vld); end
    tests++; if ({q[2].last, q[2].err, q[2].vld} !== 3'b101) begin
      fails++; $display("FAIL mwr3_last got last/err/vld=%b%b%b exp 101", q[2].last, q[2].err, q[2].vld); end
    tests++; if (cnt_tlp !== 16'd1) begin fails++; $display("FAIL mwr3_cnt_tlp got %0d exp 1", cnt_tlp); end
  endtask

  task automatic test_cpl();
    q.delete();
    qb.delete();
    send({32'h0000_3300, dw0(2'b10, 5'b01010, 10'd1)}, 1'b0);
    send({32'hCAFE_F00D, 32'h0000_5A00}, 1'b1);
    send_b({32'd0, 32'h1000_0000, 32'h0000_7700, dw0(2'b00, 5'd0, 10'd1)}, 1'b1);
    send_b({32'd0, 32'h0000_3C00, 32'h0000_1100, dw0(2'b00, 5'b01010, 10'd0)}, 1'b1);
    flush();
    tests++; if (q.size() !== 2) begin fails++; $display("FAIL cpld_writes got %0d exp 2", q.size()); end
    tests++; if ({q[0].len, q[0].tag, q[0].last} !== {13'd16, 8'h5A, 1'b0}) begin
      fails++; $display("FAIL cpld_hdr got len=%0d tag=%h exp len=16 tag=5a", q[0].len, q[0].tag); end
    tests++; if (cnt_tlp !== 16'd2) begin fails++; $display("FAIL cpld_cnt_tlp got %0d exp 2", cnt_tlp); end
    tests++; if (qb.size() !== 2) begin fails++; $display("FAIL w128_writes got %0d exp 2", qb.size()); end
    tests++; if ({qb[0].len, qb[0].tag, qb[0].last, qb[0].err} !== {13'd12, 8'h77, 2'b10}) begin
      fails++; $display("FAIL w128_mrd got len=%0d tag=%h last=%b exp len=12 tag=77 last=1", qb[0].len, qb[0].tag, qb[0].last); end
    tests++; if ({qb[1].len, qb[1].tag, qb[1].last} !== {13'd12, 8'h3C, 1'b1}) begin
      fails++; $display("FAIL w128_cpl got len=%0d tag=%h exp len=12 tag=3c", qb[1].len, qb[1].tag); end
    tests++; if (cnt_tlp_b !== 16'd2) begin fails++; $display("FAIL w128_cnt_tlp got %0d exp 2", cnt_tlp_b); end
  endtask

  task automatic test_len0();
    q.delete();
    send({32'h0000_0100, dw0(2'b10, 5'd0, 10'd0)}, 1'b0);
    send(64'h0, 1'b1);
    send({32'h0000_0200, dw0(2'b11, 5'd0, 10'd0)}, 1'b0);
    send(64'h0, 1'b1);
    flush();
    tests++; if (q.size() !== 4) begin fails++; $display("FAIL len0_writes got %0d exp 4", q.size()); end
    tests++; if ({q[0].len, q[0].tag} !== {13'd4108, 8'h01}) begin
      fails++; $display("FAIL len0_mwr3 got len=%0d tag=%h exp 4108/01", q[0].len, q[0].tag); end
    tests++; if ({q[2].len, q[2].tag} !== {13'd4112, 8'h02}) begin
      fails++; $display("FAIL len0_mwr4 got len=%0d tag=%h exp 4112/02", q[2].len, q[2].tag); end
    tests++; if (cnt_tlp !== 16'd4) begin fails++; $display("FAIL len0_cnt_tlp got %0d exp 4", cnt_tlp); end
  endtask

  task automatic test_filter();
    q.delete();
    cfg = 6'b111011;
    send({32'h0000_6100, dw0(2'b10, 5'd0, 10'd2)}, 1'b0);
    send(64'h1, 1'b0);
    send(64'h2, 1'b1);
    cfg = 6'h3F;
    send({32'h0000_6200, dw0(2'b10, 5'b00100, 10'd1)}, 1'b0);
    send(64'h3, 1'b1);
    send({32'h0000_6300, dw0(2'b10, 5'd0, 10'd1)}, 1'b1);
    flush();
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL filter_writes got %0d exp 0", q.size()); end
    tests++; if ({cnt_tlp, cnt_drop, cnt_err} !== {16'd4, 16'd0, 16'd0}) begin
      fails++; $display("FAIL filter_counts got %0d/%0d/%0d exp 4/0/0", cnt_tlp, cnt_drop, cnt_err); end
  endtask

  task automatic test_drop();
    q.delete();
    for (int i = 0; i < 5; i++) begin
      full = i < 3;
      send(i == 0 ? {32'h0000_7100, dw0(2'b10, 5'd0, 10'd3)} : 64'(i), i == 4);
    end
    full = 1'b0;
    send({32'h0000_1100, dw0(2'b10, 5'd0, 10'd1)}, 1'b0);
    send(64'h5, 1'b1);
    flush();
    tests++; if (cnt_drop !== 16'd1) begin fails++; $display("FAIL drop_cnt got %0d exp 1", cnt_drop); end
    tests++; if (q.size() !== 2) begin fails++; $display("FAIL drop_writes got %0d exp 2", q.size()); end
    tests++; if ({q[0].len, q[0].tag} !== {13'd16, 8'h11}) begin
      fails++; $display("FAIL drop_next_hdr got len=%0d tag=%h exp 16/11", q[0].len, q[0].tag); end
    tests++; if (cnt_tlp !== 16'd5) begin fails++; $display("FAIL drop_cnt_tlp got %0d exp 5", cnt_tlp); end
  endtask

  task automatic test_back_to_back();
    q.delete();
    send({32'h0000_2100, dw0(2'b10, 5'd0, 10'd1)}, 1'b0);
    send(64'h7, 1'b1);
    send({32'h0000_2200, dw0(2'b01, 5'd0, 10'd1)}, 1'b0);
    send(64'h8, 1'b1);
    flush();
    tests++; if (q.size() !== 4) begin fails++; $display("FAIL b2b_writes got %0d exp 4", q.size()); end
    tests++; if ({q[0].len, q[0].tag, q[1].last} !== {13'd16, 8'h21, 1'b1}) begin
      fails++; $display("FAIL b2b_first got len=%0d tag=%h last=%b exp 16/21/1", q[0].len, q[0].tag, q[1].last); end
    tests++; if ({q[2].len, q[2].tag, q[3].last} !== {13'd16, 8'h22, 1'b1}) begin
      fails++; $display("FAIL b2b_second got len=%0d tag=%h last=%b exp 16/22/1", q[2].len, q[2].tag, q[3].last); end
    tests++; if (cnt_tlp !== 16'd7) begin fails++; $display("FAIL b2b_cnt_tlp got %0d exp 7", cnt_tlp); end
  endtask

  task automatic test_full_mid();
    q.delete();
    for (int i = 0; i < 12; i++) begin
      rx64.s_tvalid = i < 6;
      rx64.s_tlast = i == 5;
      rx64.s_tdata = i == 0 ? {32'h0000_3100, dw0(2'b10, 5'd0, 10'd8)} : 64'(i);
      full = i >= 4 && i < 8;
      tick();
    end
    rx64.s_tvalid = 1'b0;
    rx64.s_tlast = 1'b0;
    full = 1'b0;
    flush();
    tests++; if (q.size() !== 3) begin fails++; $display("FAIL fullmid_writes got %0d exp 3", q.size()); end
    tests++; if ({q[0].len, q[0].tag, q[1].last, q[1].err} !== {13'd44, 8'h31, 2'b00}) begin
      fails++; $display("FAIL fullmid_data got len=%0d tag=%h exp 44/31", q[0].len, q[0].tag); end
    tests++; if ({q[2].last, q[2].err, q[2].vld} !== 3'b111) begin
      fails++; $display("FAIL fullmid_term got last/err/vld=%b%b%b exp 111", q[2].last, q[2].err, q[2].vld); end
    tests++; if ({cnt_err, cnt_tlp} !== {16'd1, 16'd7}) begin
      fails++; $display("FAIL fullmid_counts got err=%0d tlp=%0d exp 1/7", cnt_err, cnt_tlp); end
    tests++; if (full_viol !== 1'b0) begin fails++; $display("FAIL wr_while_full got %b exp 0", full_viol); end
  endtask

  task automatic test_timeout();
    int n;
    q.delete();
    send({32'h0000_4100, dw0(2'b10, 5'd0, 10'd2)}, 1'b0);
    send(64'h1, 1'b0);
    n = 0;
    while (q.size() < 3 && n < 700) begin
      tick();
      n++;
    end
    tests++; if (q.size() !== 3) begin fails++; $display("FAIL tmo_writes got %0d exp 3 within 700 cycles", q.size()); end
    tests++; if ({q[2].last, q[2].err} !== 2'b11) begin
      fails++; $display("FAIL tmo_term got last/err=%b%b exp 11", q[2].last, q[2].err); end
    tests++; if (cnt_err !== 16'd2) begin fails++; $display("FAIL tmo_cnt_err got %0d exp 2", cnt_err); end
    q.delete();
    send(64'h2, 1'b0);
    send(64'h3, 1'b1);
    flush();
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL tmo_drain got %0d writes exp 0", q.size()); end
    send({32'h0000_4200, dw0(2'b00, 5'd0, 10'd1)}, 1'b0);
    send(64'h0, 1'b1);
    flush();
    tests++; if ({q[0].len, q[0].tag, cnt_tlp} !== {13'd12, 8'h42, 16'd8}) begin
      fails++; $display("FAIL tmo_recover got len=%0d tag=%h tlp=%0d exp 12/42/8", q[0].len, q[0].tag, cnt_tlp); end
  endtask

  task automatic test_rst_mid();
    send({32'h0000_5100, dw0(2'b10, 5'd0, 10'd4)}, 1'b0);
    send(64'h1, 1'b0);
    send(64'h2, 1'b0);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL rst_pre_body got wr=%b exp 1", wr_en); end
    pcie_rst_n = 1'b0;
    #1;
    tests++; if ({wr_en, din_tvalid, din_tlast, din_tdata, din_tlp_len} !== '0) begin
      fails++; $display("FAIL rst_async_out got wr=%b vld=%b data=%h exp 0", wr_en, din_tvalid, din_tdata); end
    tests++; if ({cnt_tlp, cnt_drop, cnt_err} !== 48'd0) begin
      fails++; $display("FAIL rst_async_cnt got %0d/%0d/%0d exp 0/0/0", cnt_tlp, cnt_drop, cnt_err); end
    tick();
    pcie_rst_n = 1'b1;
    tick();
    q.delete();
    send({32'h0000_5200, dw0(2'b10, 5'd0, 10'd1)}, 1'b0);
    send(64'h9, 1'b1);
    flush();
    tests++; if (q.size() !== 2) begin fails++; $display("FAIL rst_after_writes got %0d exp 2", q.size()); end
    tests++; if ({q[0].len, q[0].tag, cnt_tlp} !== {13'd16, 8'h52, 16'd1}) begin
      fails++; $display("FAIL rst_after_hdr got len=%0d tag=%h tlp=%0d exp 16/52/1", q[0].len, q[0].tag, cnt_tlp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    {rx64.s_tready, rx64.s_tvalid, rx64.s_tlast} = 3'b100;
    rx64.s_tkeep = '1;
    rx64.s_tdata = '0;
    rx64.s_tuser = '0;
    {rx128.s_tready, rx128.s_tvalid, rx128.s_tlast} = 3'b100;
    rx128.s_tkeep = '1;
    rx128.s_tdata = '0;
    rx128.s_tuser = '0;
    cfg = 6'h3F;
    full = 1'b0;
    test_reset();
    test_mwr3();
    test_cpl();
    test_len0();
    test_filter();
    test_drop();
    test_back_to_back();
    test_full_mid();
    test_timeout();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
